// File: rtl/axi_lite_pkg.sv
// Shared constants and types for the AXI4-Lite command master.
// Also holds the FIR register map that the master is normally pointed at.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4,
    ST_RSP     = 3'd5
  } master_state_e;

  localparam logic [7:0] FIR_CTRL         = 8'h00;
  localparam logic [7:0] FIR_STATUS       = 8'h04;
  localparam logic [7:0] FIR_NUM_TAPS     = 8'h08;
  localparam logic [7:0] FIR_COEFF0       = 8'h0C;
  localparam logic [7:0] FIR_COEFF1       = 8'h10;
  localparam logic [7:0] FIR_COEFF2       = 8'h14;
  localparam logic [7:0] FIR_COEFF3       = 8'h18;
  localparam logic [7:0] FIR_SAMPLE_COUNT = 8'h1C;

  // States in which the master is waiting on the slave; the watchdog counts these.
  function automatic logic is_wait_state(master_state_e s);
    return (s == ST_WR_REQ) || (s == ST_WR_RESP) ||
           (s == ST_RD_REQ) || (s == ST_RD_RESP);
  endfunction

endpackage

// File: rtl/axi_lite_master_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi_lite_if #(
  parameter int addr_width = 32,
  parameter int data_width = 32
) ();

  logic [addr_width-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [data_width-1:0]   wdata;
  logic [data_width/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [addr_width-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [data_width-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axi_lite_master_hang_watchdog.sv
// Saturating per-transaction wait counter with a sticky hang flag.
// Only observes; it never aborts the transaction in flight.
module hang_watchdog #(
  parameter int hang_cycles = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic busy,
  output logic hang
);

  localparam int cnt_w = (hang_cycles < 1) ? 1 : $clog2(hang_cycles + 1);
  localparam logic [cnt_w-1:0] limit = cnt_w'(hang_cycles);

  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic             hang_q, hang_d;

  always_comb begin
    cnt_d  = cnt_q;
    hang_d = hang_q;
    if (clear) begin
      cnt_d = '0;
    end else if (busy && (cnt_q != limit)) begin
      cnt_d = cnt_q + cnt_w'(1);
    end
    if (busy && (cnt_d == limit)) begin
      hang_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      hang_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hang_q <= hang_d;
    end
  end

  assign hang = hang_q;

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator driven by a command/response stream.
//
// state      | meaning
// IDLE       | cmd_ready high, waiting for a command
// WR_REQ     | awvalid/wvalid up until each has handshaken
// WR_RESP    | bready high, waiting for bvalid
// RD_REQ     | arvalid up, waiting for arready
// RD_RESP    | rready high, waiting for rvalid
// RSP        | rsp_valid high, holding the response until rsp_ready
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int axi_addr_width = 32,
  parameter int axi_data_width = 32,
  parameter int hang_cycles    = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [axi_addr_width-1:0]   cmd_addr,
  input  logic [axi_data_width-1:0]   cmd_wdata,
  input  logic [axi_data_width/8-1:0] cmd_wstrb,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_write,
  output logic [axi_data_width-1:0]   rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic                        hang,
  output logic [31:0]                 txn_count,
  axi_lite_if.master                  m_axi
);

  localparam int strb_width = axi_data_width / 8;

  master_state_e               state_q, state_d;
  logic [axi_addr_width-1:0]   addr_q, addr_d;
  logic [axi_data_width-1:0]   wdata_q, wdata_d;
  logic [strb_width-1:0]       wstrb_q, wstrb_d;
  logic                        write_q, write_d;
  logic                        awvalid_q, awvalid_d;
  logic                        wvalid_q, wvalid_d;
  logic                        arvalid_q, arvalid_d;
  logic                        bready_q, bready_d;
  logic                        rready_q, rready_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic                        rsp_write_q, rsp_write_d;
  logic [axi_data_width-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                  rsp_resp_q, rsp_resp_d;
  logic [31:0]                 txn_count_q, txn_count_d;

  logic cmd_fire;
  logic aw_done;
  logic w_done;

  assign cmd_fire = (state_q == ST_IDLE) && cmd_valid;

  // A channel counts as done if it already handshook or handshakes this cycle.
  assign aw_done = !awvalid_q || m_axi.awready;
  assign w_done  = !wvalid_q  || m_axi.wready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    write_d     = write_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    txn_count_d = txn_count_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          write_d = cmd_write;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_REQ;
          end
        end
      end

      ST_WR_REQ: begin
        if (awvalid_q && m_axi.awready) begin
          awvalid_d = 1'b0;
        end
        if (wvalid_q && m_axi.wready) begin
          wvalid_d = 1'b0;
        end
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end

      ST_WR_RESP: begin
        if (m_axi.bvalid) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = write_q;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_axi.bresp;
          state_d     = ST_RSP;
        end
      end

      ST_RD_REQ: begin
        if (m_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_RESP;
        end
      end

      ST_RD_RESP: begin
        if (m_axi.rvalid) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = write_q;
          rsp_rdata_d = m_axi.rdata;
          rsp_resp_d  = m_axi.rresp;
          state_d     = ST_RSP;
        end
      end

      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          txn_count_d = txn_count_q + 32'd1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      write_q     <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      txn_count_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      write_q     <= write_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      txn_count_q <= txn_count_d;
    end
  end

  hang_watchdog #(
    .hang_cycles(hang_cycles)
  ) u_hang_watchdog (
    .clk  (clk),
    .rst  (rst),
    .clear(cmd_fire),
    .busy (is_wait_state(state_q)),
    .hang (hang)
  );

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign txn_count = txn_count_q;

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: memory-backed AXI-Lite slave with per-channel delays,
// directed vector table, randomized traffic against a memory model, corner sequences.
module tb_axi_lite_master;
  import axi_lite_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int HANG = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        hang;
  logic [31:0] txn_count;

  always #5 clk = ~clk;

  axi_lite_if #(.addr_width(AW), .data_width(DW)) bus ();

  axi_lite_master #(
    .axi_addr_width(AW), .axi_data_width(DW), .hang_cycles(HANG)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .hang(hang), .txn_count(txn_count),
    .m_axi(bus)
  );

  // ---------------- slave ----------------
  function automatic logic is_err(input logic [31:0] a);
    return a[31:6] != 26'd0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  bit ar_never = 1'b0;

  logic [31:0] s_mem [16];
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic        aw_have, w_have, ar_have;
  logic [31:0] aw_addr_r, w_data_r, ar_addr_r;
  logic [3:0]  w_strb_r;
  logic        s_bvalid, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;

  logic        aw_fire, w_fire, ar_fire, aw_now, w_now, ar_now;
  logic [31:0] s_wa, s_wd, s_ra;
  logic [3:0]  s_ws;

  assign bus.awready = bus.awvalid && !aw_have && (aw_cnt >= aw_dly);
  assign bus.wready  = bus.wvalid && !w_have && (w_cnt >= w_dly);
  assign bus.arready = bus.arvalid && !ar_have && !ar_never && (ar_cnt >= ar_dly);
  assign bus.bvalid  = s_bvalid;
  assign bus.bresp   = s_bresp;
  assign bus.rvalid  = s_rvalid;
  assign bus.rresp   = s_rresp;
  assign bus.rdata   = s_rdata;

  assign aw_fire = bus.awvalid && bus.awready;
  assign w_fire  = bus.wvalid && bus.wready;
  assign ar_fire = bus.arvalid && bus.arready;
  assign aw_now  = aw_have || aw_fire;
  assign w_now   = w_have || w_fire;
  assign ar_now  = ar_have || ar_fire;
  assign s_wa    = aw_have ? aw_addr_r : bus.awaddr;
  assign s_wd    = w_have ? w_data_r : bus.wdata;
  assign s_ws    = w_have ? w_strb_r : bus.wstrb;
  assign s_ra    = ar_have ? ar_addr_r : bus.araddr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) s_mem[i] <= (i == 8) ? 32'hDEADBEEF : 32'h0;
      aw_have <= 0; w_have <= 0; ar_have <= 0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_addr_r <= 0; w_data_r <= 0; w_strb_r <= 0; ar_addr_r <= 0;
      s_bvalid <= 0; s_rvalid <= 0; s_bresp <= 0; s_rresp <= 0; s_rdata <= 0;
    end else begin
      if (aw_fire) begin
        aw_have <= 1; aw_addr_r <= bus.awaddr; aw_cnt <= 0;
      end else if (bus.awvalid && !aw_have) aw_cnt <= aw_cnt + 1;
      if (w_fire) begin
        w_have <= 1; w_data_r <= bus.wdata; w_strb_r <= bus.wstrb; w_cnt <= 0;
      end else if (bus.wvalid && !w_have) w_cnt <= w_cnt + 1;
      if (!s_bvalid && aw_now && w_now) begin
        if (b_cnt >= b_dly) begin
          s_bvalid <= 1;
          s_bresp  <= is_err(s_wa) ? RESP_SLVERR : RESP_OKAY;
          if (!is_err(s_wa)) s_mem[s_wa[5:2]] <= merge(s_mem[s_wa[5:2]], s_wd, s_ws);
          b_cnt <= 0;
        end else b_cnt <= b_cnt + 1;
      end
      if (s_bvalid && bus.bready) begin
        s_bvalid <= 0; aw_have <= 0; w_have <= 0;
      end
      if (ar_fire) begin
        ar_have <= 1; ar_addr_r <= bus.araddr; ar_cnt <= 0;
      end else if (bus.arvalid && !ar_have) ar_cnt <= ar_cnt + 1;
      if (!s_rvalid && ar_now) begin
        if (r_cnt >= r_dly) begin
          s_rvalid <= 1;
          s_rdata  <= is_err(s_ra) ? 32'hBAD00BAD : s_mem[s_ra[5:2]];
          s_rresp  <= is_err(s_ra) ? RESP_DECERR : RESP_OKAY;
          r_cnt <= 0;
        end else r_cnt <= r_cnt + 1;
      end
      if (s_rvalid && bus.rready) begin
        s_rvalid <= 0; ar_have <= 0;
      end
    end
  end

  // ---------------- monitor (samples on the falling edge) ----------------
  int cyc = 0, aw_fires = 0, w_fires = 0, ar_fires = 0;
  int aw_fire_cyc = 0, w_fire_cyc = 0, bready_rise_cyc = 0, split_cnt = 0, viol = 0;
  logic        p_bready = 0, p_awpend = 0, p_wpend = 0, p_arpend = 0;
  logic [31:0] p_awaddr = 0, p_wdata = 0, p_araddr = 0;
  logic [3:0]  p_wstrb = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      p_bready <= 0; p_awpend <= 0; p_wpend <= 0; p_arpend <= 0;
    end else begin
      if (aw_fire) begin aw_fires <= aw_fires + 1; aw_fire_cyc <= cyc; end
      if (w_fire)  begin w_fires <= w_fires + 1; w_fire_cyc <= cyc; end
      if (ar_fire) ar_fires <= ar_fires + 1;
      if (bus.bready && !p_bready) bready_rise_cyc <= cyc;
      if (!bus.awvalid && bus.wvalid) split_cnt <= split_cnt + 1;
      if ((p_awpend && (!bus.awvalid || bus.awaddr != p_awaddr)) ||
          (p_wpend && (!bus.wvalid || bus.wdata != p_wdata || bus.wstrb != p_wstrb)) ||
          (p_arpend && (!bus.arvalid || bus.araddr != p_araddr)))
        viol <= viol + 1;
      p_bready <= bus.bready;
      p_awpend <= bus.awvalid && !bus.awready; p_awaddr <= bus.awaddr;
      p_wpend  <= bus.wvalid && !bus.wready;   p_wdata <= bus.wdata; p_wstrb <= bus.wstrb;
      p_arpend <= bus.arvalid && !bus.arready; p_araddr <= bus.araddr;
    end
  end

  // ---------------- checking ----------------
  int total = 0, bad = 0, exp_txn = 0;
  logic [31:0] ref_mem [16];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: a flat word memory; addresses from 0x40 up error out.
  task automatic model_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] er, output logic [1:0] eresp);
    int idx;
    idx = int'(a % 64) / 4;
    if (a >= 32'h40) begin
      er    = w ? 32'h0 : 32'hBAD00BAD;
      eresp = w ? 2'b10 : 2'b11;
    end else if (w) begin
      for (int i = 0; i < 4; i++) if (s[i]) ref_mem[idx][8*i +: 8] = d[8*i +: 8];
      er = 0; eresp = 2'b00;
    end else begin
      er = ref_mem[idx]; eresp = 2'b00;
    end
  endtask

  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int rdly,
                        output logic [31:0] rd, output logic [1:0] rr, output logic rw,
                        output int lat, output bit ok);
    int k;
    ok = 0; rd = 0; rr = 0; rw = 0; lat = 0;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    k = 0;
    while (!cmd_ready && k < 200) begin @(negedge clk); k++; end
    if (!cmd_ready) begin
      chk("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
      cmd_valid = 0;
      return;
    end
    @(negedge clk);
    cmd_valid = 0;
    k = 1;
    while (!rsp_valid && k < 300) begin @(negedge clk); k++; end
    if (!rsp_valid) begin
      chk("rsp_timeout", 64'(rsp_valid), 64'd1);
      return;
    end
    lat = k;
    repeat (rdly) @(negedge clk);
    rd = rsp_rdata; rr = rsp_resp; rw = rsp_write;
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    exp_txn++;
    chk("txn_count", 64'(txn_count), 64'(exp_txn));
    ok = 1;
  endtask

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, er, snap_rd;
    logic [1:0]  rr, eresp, snap_rr;
    logic        rw;
    int          lat, aw0, w0, ar0, sp0, k;
    bit          ok;

    vecs[0] = '{1'b1, 32'h0C, 32'h0000_1000, 4'hF, 32'h0,         RESP_OKAY};
    vecs[1] = '{1'b0, 32'h0C, 32'h0,         4'h0, 32'h0000_1000, RESP_OKAY};
    vecs[2] = '{1'b0, 32'h20, 32'h0,         4'h0, 32'hDEADBEEF,  RESP_OKAY};
    vecs[3] = '{1'b1, 32'h10, 32'hA5A5_A5A5, 4'h5, 32'h0,         RESP_OKAY};
    vecs[4] = '{1'b0, 32'h10, 32'h0,         4'h0, 32'h00A5_00A5, RESP_OKAY};
    vecs[5] = '{1'b1, 32'h40, 32'hFFFF_FFFF, 4'hF, 32'h0,         RESP_SLVERR};
    vecs[6] = '{1'b0, 32'h80, 32'h0,         4'h0, 32'hBAD0_0BAD, RESP_DECERR};
    vecs[7] = '{1'b1, 32'h04, 32'h1234_5678, 4'h3, 32'h0,         RESP_OKAY};
    vecs[8] = '{1'b0, 32'h04, 32'h0,         4'h0, 32'h0000_5678, RESP_OKAY};
    vecs[9] = '{1'b0, 32'h00, 32'h0,         4'h0, 32'h0,         RESP_OKAY};

    for (int i = 0; i < 16; i++) ref_mem[i] = (i == 8) ? 32'hDEADBEEF : 32'h0;

    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("reset_ctrl", 64'({cmd_ready, bus.awvalid, bus.wvalid, bus.arvalid, bus.bready,
                           bus.rready, rsp_valid, hang}), 64'h80);
    chk("reset_rsp", 64'({rsp_write, rsp_rdata, rsp_resp}), 64'd0);
    chk("reset_txn", 64'(txn_count), 64'd0);
    chk("reset_bus", 64'({bus.awaddr, bus.wdata, bus.wstrb, bus.awprot, bus.arprot}), 64'd0);

    // directed vector table, zero-wait slave
    for (int i = 0; i < 10; i++) begin
      aw0 = aw_fires; w0 = w_fires; ar0 = ar_fires;
      do_txn(vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].strb, 0, rd, rr, rw, lat, ok);
      model_txn(vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].strb, er, eresp);
      if (ok) begin
        chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
        chk($sformatf("vec%0d_resp", i), 64'(rr), 64'(vecs[i].exp_resp));
        chk($sformatf("vec%0d_write", i), 64'(rw), 64'(vecs[i].w));
        chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
        if (vecs[i].w)
          chk($sformatf("vec%0d_awfires_wfires_arfires", i),
              64'({8'(aw_fires - aw0), 8'(w_fires - w0), 8'(ar_fires - ar0)}), 64'h010100);
        else
          chk($sformatf("vec%0d_awfires_wfires_arfires", i),
              64'({8'(aw_fires - aw0), 8'(w_fires - w0), 8'(ar_fires - ar0)}), 64'h000001);
        if (i == 0) chk("vec0_aw_w_same_cycle", 64'(aw_fire_cyc), 64'(w_fire_cyc));
      end
    end

    // randomized traffic against the memory model
    for (int n = 0; n < 60; n++) begin
      logic        w;
      logic [31:0] a, d;
      logic [3:0]  s;
      w = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 31)) << 2;
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      r_dly = $urandom_range(0, 3);
      do_txn(w, a, d, s, $urandom_range(0, 3), rd, rr, rw, lat, ok);
      model_txn(w, a, d, s, er, eresp);
      if (ok) begin
        chk($sformatf("rand%0d_rdata", n), 64'(rd), 64'(er));
        chk($sformatf("rand%0d_resp", n), 64'(rr), 64'(eresp));
        chk($sformatf("rand%0d_write", n), 64'(rw), 64'(w));
      end
    end
    aw_dly = 0; w_dly = 0; ar_dly = 0; b_dly = 0; r_dly = 0;

    // wready held low for 5 cycles after the aw handshake
    w_dly = 6;
    sp0 = split_cnt;
    do_txn(1'b1, 32'h14, 32'h0BAD_F00D, 4'hF, 0, rd, rr, rw, lat, ok);
    model_txn(1'b1, 32'h14, 32'h0BAD_F00D, 4'hF, er, eresp);
    w_dly = 0;
    if (ok) begin
      chk("split_w_after_aw_cycles", 64'(w_fire_cyc - aw_fire_cyc), 64'd6);
      chk("split_bready_after_w", 64'(bready_rise_cyc - w_fire_cyc), 64'd1);
      chk("split_aw_dropped_w_held", 64'(split_cnt - sp0), 64'd6);
      chk("split_resp", 64'({rw, rr, rd}), 64'({1'b1, RESP_OKAY, 32'h0}));
    end

    // response held back 10 cycles while a second command waits
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h14; cmd_wdata = 0; cmd_wstrb = 0;
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    @(negedge clk);
    cmd_valid = 0;
    k = 0;
    while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
    chk("hold_rsp_seen", 64'(rsp_valid), 64'd1);
    model_txn(1'b0, 32'h14, 32'h0, 4'h0, er, eresp);
    snap_rd = rsp_rdata; snap_rr = rsp_resp;
    chk("hold_rdata", 64'({snap_rr, snap_rd}), 64'({eresp, er}));
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h18; cmd_wdata = 32'h1111_2222; cmd_wstrb = 4'hF;
    aw0 = aw_fires;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("hold_stable_c%0d", c),
          64'({rsp_valid, rsp_write, rsp_rdata, rsp_resp, cmd_ready, bus.awvalid}),
          64'({1'b1, 1'b0, snap_rd, snap_rr, 1'b0, 1'b0}));
    end
    chk("hold_no_new_aw", 64'(aw_fires - aw0), 64'd0);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    exp_txn++;
    chk("hold_release", 64'({cmd_ready, rsp_valid}), 64'b10);
    chk("hold_txn_count", 64'(txn_count), 64'(exp_txn));
    @(negedge clk);
    chk("hold_next_accepted", 64'({cmd_ready, bus.awvalid, bus.wvalid}), 64'b011);
    cmd_valid = 0;
    k = 0;
    while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
    model_txn(1'b1, 32'h18, 32'h1111_2222, 4'hF, er, eresp);
    chk("hold_second_resp", 64'({rsp_valid, rsp_write, rsp_resp, rsp_rdata}),
        64'({1'b1, 1'b1, eresp, er}));
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    exp_txn++;
    chk("hold_second_txn_count", 64'(txn_count), 64'(exp_txn));

    // slave never grants arready: hang after HANG waiting cycles
    ar_never = 1;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h00;
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    @(negedge clk);
    cmd_valid = 0;
    repeat (HANG - 1) @(negedge clk);
    chk("hang_not_yet", 64'(hang), 64'd0);
    @(negedge clk);
    chk("hang_set", 64'(hang), 64'd1);
    repeat (10) @(negedge clk);
    chk("hang_sticky_arvalid_norsp", 64'({hang, bus.arvalid, rsp_valid}), 64'b110);

    // let the read proceed into RD_RESP, then reset mid-transaction
    r_dly = 40;
    ar_never = 0;
    k = 0;
    while (!bus.rready && k < 20) begin @(negedge clk); k++; end
    chk("rd_resp_reached", 64'(bus.rready), 64'd1);
    #1 rst = 1;
    @(posedge clk);
    #1;
    chk("midrst_ctrl", 64'({cmd_ready, bus.awvalid, bus.wvalid, bus.arvalid, bus.bready,
                            bus.rready, rsp_valid, hang}), 64'h80);
    chk("midrst_txn", 64'(txn_count), 64'd0);
    @(negedge clk);
    rst = 0;
    r_dly = 0;
    @(negedge clk);
    chk("post_rst_idle", 64'({cmd_ready, rsp_valid, hang}), 64'b100);
    chk("protocol_stability", 64'(viol), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
